// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register offsets, reset constants and pin limit shared by the gpio_bank slice
package gpio_bank_pkg;
  localparam int MAX_PINS = 32;
  localparam logic [7:0] OFF_DATA = 8'h00;
  localparam logic [7:0] OFF_OUT  = 8'h04;
  localparam logic [7:0] OFF_OEB  = 8'h08;
  localparam logic [7:0] OFF_PU   = 8'h0C;
  localparam logic [7:0] OFF_PD   = 8'h10;
  localparam logic [7:0] OFF_REN  = 8'h14;
  localparam logic [7:0] OFF_FEN  = 8'h18;
  localparam logic [7:0] OFF_IRQ  = 8'h1C;
  localparam logic [7:0] OFF_DEB  = 8'h20;
  localparam logic [MAX_PINS-1:0] OEB_RST = '1;
endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: iomem-style memory bus between the wishbone adapter (master) and a peripheral (slave)
interface gpio_bank_if;
  logic        iomem_valid;
  logic [31:0] iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;
  modport master (output iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, input iomem_rdata, iomem_ready);
  modport slave  (input iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, output iomem_rdata, iomem_ready);
endinterface

// File: rtl/gpio_bank_pin_filter.sv
// gpio_bank_pin_filter: one pin's synchroniser, optional debounce (GPIO_BANK_DEBOUNCE_EN) and edge detect
module gpio_bank_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pad,
  input  logic                  armed,
  input  logic [DEBOUNCE_W-1:0] debounce,
  output logic                  filt,
  output logic                  rise,
  output logic                  fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk) begin
    sync <= resetn ? {sync[SYNC_STAGES-2:0], pad} : '0;
    prev <= resetn ? filt : 1'b0;
  end
`ifdef GPIO_BANK_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cnt;
  logic held;
  // >= keeps a lowered threshold from letting cnt run past it and wrap
  always_ff @(posedge clk)
    if (!resetn) begin
      cnt  <= '0;
      held <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == held) cnt <= '0;
    else if (cnt >= debounce) begin
      cnt  <= '0;
      held <= sync[SYNC_STAGES-1];
    end else cnt <= cnt + 1'b1;
  assign filt = (debounce == '0) ? sync[SYNC_STAGES-1] : held;
`else
  logic unused_debounce;
  assign unused_debounce = ^debounce;
  assign filt = sync[SYNC_STAGES-1];
`endif
  assign rise = armed & filt & ~prev;
  assign fall = armed & ~filt & prev;
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: multi-pin GPIO bank on the iomem bus with latched edge interrupts; debounce built with GPIO_BANK_DEBOUNCE_EN
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h2100_0000,
  parameter int          N_PINS      = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          DEBOUNCE_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  gpio_bank_if.slave        bus,
  input  logic [N_PINS-1:0] gpio_in_pad,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oeb,
  output logic [N_PINS-1:0] gpio_pu,
  output logic [N_PINS-1:0] gpio_pd,
  output logic              irq
);
  localparam logic [31:0] PIN_MASK = 32'hFFFF_FFFF >> (MAX_PINS - N_PINS);
  localparam logic [31:0] DEB_MASK = 32'hFFFF_FFFF >> (32 - DEBOUNCE_W);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  logic hit, wr, armed, ready_q;
  logic [7:0] off;
  logic [31:0] bmask, wdata, rd, rdata_q, st_d;
  logic [31:0] out_q, oeb_q, pu_q, pd_q, ren_q, fen_q, st_q, deb_q;
  logic [N_PINS-1:0] filt, rise, fall;
  logic [ARM_W-1:0] arm_cnt;
  assign off   = bus.iomem_addr[7:0];
  assign wdata = bus.iomem_wdata;
  assign hit   = bus.iomem_valid & ~ready_q & (bus.iomem_addr[31:8] == BASE_ADR[31:8]);
  assign wr    = hit & |bus.iomem_wstrb;
  assign bmask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}}, {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
  assign armed = arm_cnt == ARM_DONE;
  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  function automatic logic [31:0] upd(input logic [31:0] cur, input logic [7:0] o, input logic [31:0] keep);
    return (wr && off == o) ? ((cur & ~bmask) | (wdata & bmask)) & keep : cur;
  endfunction
  // a new edge is OR-ed in after the W1C clear so a same-cycle set wins
  assign st_d = ((st_q & ~((wr && off == OFF_IRQ) ? wdata & bmask : '0)) |
                 (32'(rise) & ren_q) | (32'(fall) & fen_q)) & PIN_MASK;
  always_comb
    case (off)
      OFF_DATA: rd = 32'(filt);
      OFF_OUT:  rd = out_q;
      OFF_OEB:  rd = oeb_q;
      OFF_PU:   rd = pu_q;
      OFF_PD:   rd = pd_q;
      OFF_REN:  rd = ren_q;
      OFF_FEN:  rd = fen_q;
      OFF_IRQ:  rd = st_q;
      OFF_DEB:  rd = deb_q;
      default:  rd = '0;
    endcase
  always_ff @(posedge clk)
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      oeb_q   <= OEB_RST & PIN_MASK;
      pu_q    <= '0;
      pd_q    <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      st_q    <= '0;
      irq     <= 1'b0;
      arm_cnt <= '0;
    end else begin
      ready_q <= hit;
      rdata_q <= hit ? rd : '0;
      out_q   <= upd(upd(out_q, OFF_DATA, PIN_MASK), OFF_OUT, PIN_MASK);
      oeb_q   <= upd(oeb_q, OFF_OEB, PIN_MASK);
      pu_q    <= upd(pu_q, OFF_PU, PIN_MASK);
      pd_q    <= upd(pd_q, OFF_PD, PIN_MASK);
      ren_q   <= upd(ren_q, OFF_REN, PIN_MASK);
      fen_q   <= upd(fen_q, OFF_FEN, PIN_MASK);
      st_q    <= st_d;
      irq     <= |st_d;
      arm_cnt <= armed ? arm_cnt : arm_cnt + 1'b1;
    end
`ifdef GPIO_BANK_DEBOUNCE_EN
  always_ff @(posedge clk) deb_q <= resetn ? upd(deb_q, OFF_DEB, DEB_MASK) : '0;
`else
  assign deb_q = '0;
`endif
  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_bank_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)) u_filt (
      .clk(clk), .resetn(resetn), .pad(gpio_in_pad[i]), .armed(armed),
      .debounce(deb_q[DEBOUNCE_W-1:0]), .filt(filt[i]), .rise(rise[i]), .fall(fall[i]));
  end
  assign gpio_out = out_q[N_PINS-1:0];
  assign gpio_oeb = oeb_q[N_PINS-1:0];
  assign gpio_pu  = pu_q[N_PINS-1:0];
  assign gpio_pd  = pd_q[N_PINS-1:0] & ~pu_q[N_PINS-1:0];
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: randomized scoreboard bench for gpio_bank against a register-level reference model
module tb_gpio_bank;
  localparam logic [31:0] BASE = 32'h2100_0000;
  localparam logic [31:0] PM = 32'h0000_FFFF;
  localparam int SETTLE = 12;
  typedef struct {
    logic        rd;
    logic [7:0]  off;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [15:0] pad, gpio_out, gpio_oeb, gpio_pu, gpio_pd;
  logic irq;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] m_out = 0, m_oeb = 32'hFFFF, m_pu = 0, m_pd = 0, m_re = 0, m_fe = 0, m_st = 0, m_deb = 0, m_pad = 0;
  logic [7:0] offs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h40, 8'hFC};
  gpio_bank_if bus();
  gpio_bank dut (.clk(clk), .resetn(resetn), .bus(bus), .gpio_in_pad(pad), .gpio_out(gpio_out),
                 .gpio_oeb(gpio_oeb), .gpio_pu(gpio_pu), .gpio_pd(gpio_pd), .irq(irq));
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction
  function automatic logic [31:0] merge(logic [31:0] cur, logic [3:0] ws, logic [31:0] wd);
    for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
    return cur & PM;
  endfunction
  function automatic logic [31:0] m_read(logic [7:0] off);
    case (off)
      8'h00: return m_pad;
      8'h04: return m_out;
      8'h08: return m_oeb;
      8'h0C: return m_pu;
      8'h10: return m_pd;
      8'h14: return m_re;
      8'h18: return m_fe;
      8'h1C: return m_st;
      8'h20: return m_deb;
      default: return 32'h0;
    endcase
  endfunction
  function automatic void m_write(logic [7:0] off, logic [3:0] ws, logic [31:0] wd);
    case (off)
      8'h00, 8'h04: m_out = merge(m_out, ws, wd);
      8'h08: m_oeb = merge(m_oeb, ws, wd);
      8'h0C: m_pu = merge(m_pu, ws, wd);
      8'h10: m_pd = merge(m_pd, ws, wd);
      8'h14: m_re = merge(m_re, ws, wd);
      8'h18: m_fe = merge(m_fe, ws, wd);
      8'h1C: m_st = m_st & ~merge(32'h0, ws, wd);
`ifdef GPIO_BANK_DEBOUNCE_EN
      8'h20: m_deb = merge(m_deb, ws, wd) & 32'hFF;
`endif
      default: ;
    endcase
  endfunction
  task automatic chk_io();
    chk("gpio_out", {16'h0, gpio_out}, m_out);
    chk("gpio_oeb", {16'h0, gpio_oeb}, m_oeb);
    chk("gpio_pu", {16'h0, gpio_pu}, m_pu);
    chk("gpio_pd", {16'h0, gpio_pd}, m_pd & ~m_pu);
    chk("irq", {31'h0, irq}, {31'h0, m_st != 0});
  endtask
  // called at a falling edge; returns at a falling edge with the bus idle again
  task automatic access(input logic [7:0] off, input logic [3:0] ws, input logic [31:0] wd, input logic [31:0] set_m);
    q.push_back('{ws == 4'h0, off, m_read(off)});
    m_write(off, ws, wd);
    m_st |= set_m;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE | {24'h0, off};
    bus.iomem_wstrb = ws;
    bus.iomem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    chk("ack", {31'h0, bus.iomem_ready}, 32'h1);
    chk_io();
    @(negedge clk);
  endtask
  task automatic set_pad(input logic [15:0] v);
    logic [31:0] nv;
    nv = {16'h0, v};
    m_st |= ((nv & ~m_pad & m_re) | (~nv & m_pad & m_fe)) & PM;
    m_pad = nv;
    pad = v;
    repeat (SETTLE) @(negedge clk);
    chk("irq_after_pad", {31'h0, irq}, {31'h0, m_st != 0});
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.iomem_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ready=1 at addr %h, expected no acknowledge", bus.iomem_addr);
      end else begin
        e = q.pop_front();
        if (e.rd) chk($sformatf("read_%02h", e.off), bus.iomem_rdata, e.exp);
      end
    end
  end
  initial begin
    logic [7:0] o;
    logic [3:0] ws;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = 32'h0;
    pad = 16'hA5A5;
    m_pad = 32'hA5A5;
    repeat (3) @(negedge clk);
    chk("rst_oeb", {16'h0, gpio_oeb}, 32'hFFFF);
    chk("rst_out", {16'h0, gpio_out}, 32'h0);
    chk("rst_pu_pd", {gpio_pu, gpio_pd}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ready", {31'h0, bus.iomem_ready}, 32'h0);
    resetn = 1'b1;
    repeat (SETTLE) @(negedge clk);
    foreach (offs[i]) access(offs[i], 4'h0, 32'h0, 32'h0);
    access(8'h04, 4'b0001, 32'h1234_5678, 32'h0);
    access(8'h04, 4'h0, 32'h0, 32'h0);
    chk("out_byte", {16'h0, gpio_out}, 32'h78);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE + 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ack_outside", {31'h0, bus.iomem_ready}, 32'h0);
    end
    bus.iomem_valid = 1'b0;
    @(negedge clk);
    access(8'h14, 4'hF, 32'h1, 32'h0);
    set_pad(pad & ~16'h1);
    pad[0] = 1'b1;
    m_pad[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    m_st |= 32'h1;
    access(8'h1C, 4'h0, 32'h0, 32'h0);
    access(8'h1C, 4'hF, 32'h1, 32'h0);
    access(8'h18, 4'hF, 32'h8, 32'h0);
    set_pad(pad | 16'h8);
    pad[3] = 1'b0;
    m_pad[3] = 1'b0;
    repeat (2) @(negedge clk);
    access(8'h1C, 4'hF, 32'h8, 32'h8);
    chk("race_irq", {31'h0, irq}, 32'h1);
    access(8'h1C, 4'h0, 32'h0, 32'h0);
    access(8'h1C, 4'hF, 32'h8, 32'h0);
    access(8'h0C, 4'hF, 32'h5, 32'h0);
    access(8'h10, 4'hF, 32'h5, 32'h0);
    chk("pd_masked", {16'h0, gpio_pd}, 32'h0);
    access(8'h0C, 4'hF, 32'h0, 32'h0);
    access(8'h10, 4'hF, 32'h2, 32'h0);
    chk("pd_alone", {16'h0, gpio_pd}, 32'h2);
    access(8'h20, 4'hF, 32'h4, 32'h0);
    access(8'h20, 4'h0, 32'h0, 32'h0);
`ifdef GPIO_BANK_DEBOUNCE_EN
    pad[1] = ~pad[1];
    repeat (4) @(negedge clk);
    pad[1] = ~pad[1];
    repeat (SETTLE) @(negedge clk);
    access(8'h00, 4'h0, 32'h0, 32'h0);
    set_pad(pad ^ 16'h2);
    access(8'h00, 4'h0, 32'h0, 32'h0);
`endif
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) set_pad(16'($urandom));
      else begin
        o = offs[$urandom_range(0, 11)];
        ws = 4'($urandom_range(0, 15));
        if (o == 8'h20) ws = 4'h0;
        access(o, ws, $urandom, 32'h0);
      end
    end
    foreach (offs[i]) access(offs[i], 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d accesses unacknowledged, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
